// File: rtl/islip_voq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : islip_voq_ctrl
//  Description : Input-side scheduling agent for an iSLIP crossbar arbiter.
//                Keeps per-input VOQ packet counts and port reservations,
//                offers a request-matrix snapshot to the arbiter, consumes
//                the match, issues dequeue commands and holds the matched
//                input/output busy until the input buffer reports done.
//  Ports       : clk/rst           - clock, synchronous active-high reset
//                enq_valid/enq_dst - per-input enqueue notification (one-hot dst)
//                tx_ok             - per-output ready from the egress side
//                arb_valid_in/arb_ready_in/rx_req_vect/tx_rdy_vect
//                                  - request matrix offered to the arbiter
//                arb_valid_out/arb_ready_out/arb_vect
//                                  - match returned by the arbiter
//                deq_valid/deq_dst/deq_done
//                                  - dequeue command and completion
//                err_ovf/err_grant - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module islip_voq_ctrl #(
    parameter int PORT_NUM  = 4,
    parameter int CNT_WIDTH = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORT_NUM-1:0]                enq_valid,
    input  logic [PORT_NUM-1:0][PORT_NUM-1:0]  enq_dst,
    input  logic [PORT_NUM-1:0]                tx_ok,
    output logic                               arb_valid_in,
    input  logic                               arb_ready_in,
    output logic [PORT_NUM-1:0][PORT_NUM-1:0]  rx_req_vect,
    output logic [PORT_NUM-1:0]                tx_rdy_vect,
    input  logic                               arb_valid_out,
    output logic                               arb_ready_out,
    input  logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_vect,
    output logic [PORT_NUM-1:0]                deq_valid,
    output logic [PORT_NUM-1:0][PORT_NUM-1:0]  deq_dst,
    input  logic [PORT_NUM-1:0]                deq_done,
    output logic                               err_ovf,
    output logic                               err_grant
);

    localparam logic [1:0]           c_st_idle = 2'd0;
    localparam logic [1:0]           c_st_req  = 2'd1;
    localparam logic [1:0]           c_st_gnt  = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [1:0]                          r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]                r_cnt [PORT_NUM][PORT_NUM];
    logic [PORT_NUM-1:0]                 r_in_busy, r_out_busy;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]   r_rx_req, r_deq_dst;
    logic [PORT_NUM-1:0]                 r_deq_valid;
    logic                                r_arb_valid_in, r_arb_ready_out;
    logic                                r_err_ovf, r_err_grant;

    logic [PORT_NUM-1:0][PORT_NUM-1:0]   w_req, w_inc, w_grant;
    logic [PORT_NUM-1:0]                 w_taken, w_free, w_done_ok;
    logic                                w_hs_gnt, w_grant_bad, w_enq_bad, w_ovf_hit;

    assign w_hs_gnt = (r_state == c_st_gnt) && arb_valid_out;

    // Request terms and enqueue decode; an increment that would wrap is
    // flagged here and suppressed in the counter update.
    always_comb begin
        w_req     = '0;
        w_inc     = '0;
        w_enq_bad = 1'b0;
        w_ovf_hit = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (enq_valid[i]) begin
                if ($onehot(enq_dst[i])) w_inc[i] = enq_dst[i];
                else                     w_enq_bad = 1'b1;
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                w_req[i][o] = (r_cnt[i][o] != '0) && !r_in_busy[i] &&
                              !r_out_busy[o] && tx_ok[o];
                if (w_inc[i][o] && !w_grant[i][o] && (r_cnt[i][o] == c_cnt_max))
                    w_ovf_hit = 1'b1;
            end
        end
    end

    // Grant filter: lower inputs claim outputs first, so a duplicate output
    // grant is only honoured for the lowest-numbered input.
    always_comb begin
        w_grant     = '0;
        w_taken     = '0;
        w_grant_bad = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (w_hs_gnt && (arb_vect[i] != '0)) begin
                if ($onehot(arb_vect[i]) && ((arb_vect[i] & ~r_rx_req[i]) == '0) &&
                    ((arb_vect[i] & w_taken) == '0)) begin
                    w_grant[i] = arb_vect[i];
                    w_taken    = w_taken | arb_vect[i];
                end else begin
                    w_grant_bad = 1'b1;
                end
            end
        end
    end

    // Completion is ignored while the dequeue pulse is still out, so a
    // done can never retire a transfer the input has not started.
    always_comb begin
        w_done_ok = deq_done & r_in_busy & ~r_deq_valid;
        w_free    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (w_done_ok[i]) w_free = w_free | r_deq_dst[i];
        end
    end

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_cnt_in
            for (genvar go = 0; go < PORT_NUM; go++) begin : g_cnt_out
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cnt[gi][go] <= '0;
                    end else if (w_inc[gi][go] && !w_grant[gi][go]) begin
                        if (r_cnt[gi][go] != c_cnt_max)
                            r_cnt[gi][go] <= r_cnt[gi][go] + c_cnt_one;
                    end else if (!w_inc[gi][go] && w_grant[gi][go]) begin
                        r_cnt[gi][go] <= r_cnt[gi][go] - c_cnt_one;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_busy   <= '0;
            r_out_busy  <= '0;
            r_deq_valid <= '0;
            r_deq_dst   <= '0;
            r_err_ovf   <= 1'b0;
            r_err_grant <= 1'b0;
        end else begin
            r_deq_valid <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (w_grant[i] != '0) begin
                    r_in_busy[i]   <= 1'b1;
                    r_deq_dst[i]   <= w_grant[i];
                    r_deq_valid[i] <= 1'b1;
                end else if (w_done_ok[i]) begin
                    r_in_busy[i] <= 1'b0;
                    r_deq_dst[i] <= '0;
                end
            end
            r_out_busy  <= (r_out_busy & ~w_free) | w_taken;
            r_err_ovf   <= r_err_ovf | w_enq_bad | w_ovf_hit;
            r_err_grant <= r_err_grant | w_grant_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_req != '0)  w_state_nxt = c_st_req;
            c_st_req:  if (arb_ready_in)  w_state_nxt = c_st_gnt;
            c_st_gnt:  if (arb_valid_out) w_state_nxt = c_st_idle;
            default:                      w_state_nxt = c_st_idle;
        endcase
    end

    // Handshake outputs and the request snapshot; the snapshot is only
    // loaded in idle so it stays frozen for the whole round.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arb_valid_in  <= 1'b0;
            r_arb_ready_out <= 1'b0;
            r_rx_req        <= '0;
        end else begin
            case (r_state)
                c_st_idle: if (w_req != '0) begin
                    r_rx_req       <= w_req;
                    r_arb_valid_in <= 1'b1;
                end
                c_st_req: if (arb_ready_in) begin
                    r_arb_valid_in  <= 1'b0;
                    r_arb_ready_out <= 1'b1;
                end
                c_st_gnt: if (arb_valid_out) begin
                    r_arb_ready_out <= 1'b0;
                    r_rx_req        <= '0;
                end
                default: begin
                    r_arb_valid_in  <= 1'b0;
                    r_arb_ready_out <= 1'b0;
                end
            endcase
        end
    end

    assign arb_valid_in  = r_arb_valid_in;
    assign arb_ready_out = r_arb_ready_out;
    assign rx_req_vect   = r_rx_req;
    assign tx_rdy_vect   = tx_ok & ~r_out_busy;
    assign deq_valid     = r_deq_valid;
    assign deq_dst       = r_deq_dst;
    assign err_ovf       = r_err_ovf;
    assign err_grant     = r_err_grant;

endmodule
`default_nettype wire

// File: tb/tb_islip_voq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_islip_voq_ctrl
//  Description : Directed self-checking bench for islip_voq_ctrl (4x4, 2-bit
//                counters). Inputs change 1 ns after the rising edge and
//                outputs are checked at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_islip_voq_ctrl;

    localparam int PORT_NUM  = 4;
    localparam int CNT_WIDTH = 2;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [PORT_NUM-1:0]               enq_valid;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] enq_dst;
    logic [PORT_NUM-1:0]               tx_ok;
    logic                              arb_valid_in;
    logic                              arb_ready_in;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] rx_req_vect;
    logic [PORT_NUM-1:0]               tx_rdy_vect;
    logic                              arb_valid_out;
    logic                              arb_ready_out;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_vect;
    logic [PORT_NUM-1:0]               deq_valid;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] deq_dst;
    logic [PORT_NUM-1:0]               deq_done;
    logic                              err_ovf;
    logic                              err_grant;

    int n_vec = 0;
    int n_err = 0;

    islip_voq_ctrl #(.PORT_NUM(PORT_NUM), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_dst(enq_dst), .tx_ok(tx_ok),
        .arb_valid_in(arb_valid_in), .arb_ready_in(arb_ready_in),
        .rx_req_vect(rx_req_vect), .tx_rdy_vect(tx_rdy_vect),
        .arb_valid_out(arb_valid_out), .arb_ready_out(arb_ready_out),
        .arb_vect(arb_vect),
        .deq_valid(deq_valid), .deq_dst(deq_dst), .deq_done(deq_done),
        .err_ovf(err_ovf), .err_grant(err_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Offer handshake then return the given match; ends in the deq_valid cycle.
    task automatic run_round(input string tag, input logic [15:0] exp_rx,
                             input logic [15:0] grant, input logic [3:0] exp_dv,
                             input logic [15:0] exp_dd);
        chk({tag, "_valid_in"}, 32'(arb_valid_in), 32'h1);
        chk({tag, "_rx_req"},   32'(rx_req_vect),  32'(exp_rx));
        arb_ready_in = 1'b1;
        step();
        arb_ready_in = 1'b0;
        chk({tag, "_ready_out"}, 32'({arb_valid_in, arb_ready_out}), 32'h1);
        arb_valid_out = 1'b1;
        arb_vect      = grant;
        step();
        arb_valid_out = 1'b0;
        arb_vect      = '0;
        chk({tag, "_deq_valid"}, 32'(deq_valid),     32'(exp_dv));
        chk({tag, "_deq_dst"},   32'(deq_dst),       32'(exp_dd));
        chk({tag, "_ready_low"}, 32'(arb_ready_out), 32'h0);
    endtask

    // Let the dequeue pulse pass, then report completion for the given inputs.
    task automatic finish_xfer(input logic [3:0] mask);
        step();
        deq_done = mask;
        step();
        deq_done = '0;
    endtask

    initial begin
        rst = 1'b1; enq_valid = '0; enq_dst = '0; tx_ok = '0;
        arb_ready_in = 1'b0; arb_valid_out = 1'b0; arb_vect = '0; deq_done = '0;
        step(); step(); step();
        chk("rst_outputs", 32'({arb_valid_in, arb_ready_out, deq_valid, err_ovf, err_grant}), 32'h0);
        chk("rst_rx_req",  32'(rx_req_vect), 32'h0);
        chk("rst_deq_dst", 32'(deq_dst),     32'h0);
        chk("rst_tx_rdy",  32'(tx_rdy_vect), 32'h0);
        rst = 1'b0;
        tx_ok = 4'hF;
        step();
        chk("idle_tx_rdy", 32'(tx_rdy_vect), 32'hF);

        // 1: single packet input0 -> output2
        enq_valid = 4'b0001; enq_dst[0] = 4'h4;
        step();
        enq_valid = '0;
        chk("t1_no_valid_t1", 32'(arb_valid_in), 32'h0);
        step();
        chk("t1_valid_t2", 32'(arb_valid_in), 32'h1);
        step();
        chk("t1_hold_valid", 32'(arb_valid_in), 32'h1);
        chk("t1_hold_rx",    32'(rx_req_vect),  32'h0004);
        run_round("t1", 16'h0004, 16'h0004, 4'b0001, 16'h0004);
        chk("t1_tx_rdy_busy", 32'(tx_rdy_vect), 32'hB);
        deq_done = 4'b0001;          // lands in the deq_valid cycle: ignored
        step();
        deq_done = '0;
        chk("t1_early_done_rdy", 32'(tx_rdy_vect), 32'hB);
        chk("t1_early_done_dst", 32'(deq_dst),     32'h0004);
        deq_done = 4'b0001;
        step();
        deq_done = '0;
        chk("t1_done_rdy", 32'(tx_rdy_vect), 32'hF);
        chk("t1_done_dst", 32'(deq_dst),     32'h0);
        step();
        chk("t1_cnt_zero", 32'(arb_valid_in), 32'h0);

        // 2: pattern {0,1,C,0}, grant {0,1,8,0}
        tx_ok = '0;
        enq_valid = 4'b0110; enq_dst[2] = 4'h1; enq_dst[1] = 4'h4;
        step();
        enq_valid = 4'b0010; enq_dst[1] = 4'h8;
        step();
        enq_valid = '0;
        step();
        chk("t2_gated", 32'(arb_valid_in), 32'h0);
        tx_ok = 4'hF;
        step();
        run_round("t2a", 16'h01C0, 16'h0180, 4'b0110, 16'h0180);
        chk("t2_tx_rdy", 32'(tx_rdy_vect), 32'h6);
        step();
        chk("t2_busy_no_req", 32'(arb_valid_in), 32'h0);
        deq_done = 4'b0110;
        step();
        deq_done = '0;
        chk("t2_freed_rdy", 32'(tx_rdy_vect), 32'hF);
        step();
        run_round("t2b", 16'h0040, 16'h0040, 4'b0010, 16'h0040);
        finish_xfer(4'b0010);

        // 3: saturation at 3 then drain
        tx_ok = '0;
        enq_valid = 4'b0100; enq_dst[2] = 4'h2;
        step(); step(); step();
        chk("t3_no_ovf_at_max", 32'(err_ovf), 32'h0);
        step();
        enq_valid = '0;
        chk("t3_ovf", 32'(err_ovf), 32'h1);
        tx_ok = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            run_round($sformatf("t3_r%0d", k), 16'h0200, 16'h0200, 4'b0100, 16'h0200);
            finish_xfer(4'b0100);
        end
        step();
        chk("t3_drained", 32'(arb_valid_in), 32'h0);

        // 4: illegal multi-hot grant on input1
        enq_valid = 4'b0010; enq_dst[1] = 4'h1;
        step();
        enq_valid = '0;
        step();
        chk("t4_err_before", 32'(err_grant), 32'h0);
        run_round("t4_bad", 16'h0010, 16'h0030, 4'b0000, 16'h0000);
        chk("t4_err_after", 32'(err_grant), 32'h1);
        step();
        run_round("t4_retry", 16'h0010, 16'h0010, 4'b0010, 16'h0010);
        finish_xfer(4'b0010);

        // 4b: inputs 0 and 1 both granted output2; input0 wins
        enq_valid = 4'b0011; enq_dst[0] = 4'h4; enq_dst[1] = 4'h4;
        step();
        enq_valid = '0;
        step();
        run_round("t4c", 16'h0044, 16'h0044, 4'b0001, 16'h0004);
        finish_xfer(4'b0001);
        step();
        run_round("t4c_left", 16'h0040, 16'h0040, 4'b0010, 16'h0040);
        finish_xfer(4'b0010);

        // 5: enq and grant on same VOQ; output3 masked by tx_ok
        tx_ok = 4'h7;
        enq_valid = 4'b0101; enq_dst[0] = 4'h2; enq_dst[2] = 4'h8;
        step();
        enq_valid = '0;
        chk("t5_tx_rdy", 32'(tx_rdy_vect), 32'h7);
        step();
        chk("t5_valid", 32'(arb_valid_in), 32'h1);
        chk("t5_rx_no_out3", 32'(rx_req_vect), 32'h0002);
        arb_ready_in = 1'b1;
        step();
        arb_ready_in = 1'b0;
        arb_valid_out = 1'b1; arb_vect = 16'h0002;
        enq_valid = 4'b0001; enq_dst[0] = 4'h2;
        step();
        arb_valid_out = 1'b0; arb_vect = '0; enq_valid = '0;
        chk("t5_deq_valid", 32'(deq_valid), 32'h1);
        finish_xfer(4'b0001);
        step();
        run_round("t5_cnt_kept", 16'h0002, 16'h0002, 4'b0001, 16'h0002);

        // 6: reset mid-round with busy flags set
        tx_ok = 4'hF;
        step();
        chk("t6_rx", 32'(rx_req_vect), 32'h0800);
        chk("t6_rdy_busy", 32'(tx_rdy_vect), 32'hD);
        arb_ready_in = 1'b1;
        step();
        arb_ready_in = 1'b0;
        chk("t6_in_gnt", 32'(arb_ready_out), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_outputs", 32'({arb_valid_in, arb_ready_out, deq_valid, err_ovf, err_grant}), 32'h0);
        chk("t6_rst_rx",  32'(rx_req_vect), 32'h0);
        chk("t6_rst_dst", 32'(deq_dst),     32'h0);
        chk("t6_rst_rdy", 32'(tx_rdy_vect), 32'hF);
        step();
        chk("t6_cnt_cleared", 32'(arb_valid_in), 32'h0);
        enq_valid = 4'b1000; enq_dst[3] = 4'h1;
        step();
        enq_valid = '0;
        step();
        run_round("t6_post", 16'h1000, 16'h1000, 4'b1000, 16'h1000);
        finish_xfer(4'b1000);
        chk("t6_post_rdy", 32'(tx_rdy_vect), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
